// File: rtl/lsu_pkg.sv
// Shared LSU definitions: funct3 encodings, access sizes, FSM states and decode helpers.
package lsu_pkg;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } funct3_load_t;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } funct3_store_t;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10
  } mem_access_size_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RD,
    S_RESP
  } lsu_state_t;

  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    logic bad;
    bad = 1'b1;
    if (is_store) begin
      if (f3 == F3_SB || f3 == F3_SH || f3 == F3_SW) bad = 1'b0;
    end else begin
      if (f3 == F3_LB || f3 == F3_LH || f3 == F3_LW || f3 == F3_LBU || f3 == F3_LHU) bad = 1'b0;
    end
    return bad;
  endfunction

  function automatic mem_access_size_t f3_size(input logic [2:0] f3);
    mem_access_size_t s;
    case (f3[1:0])
      2'b00:   s = SIZE_B;
      2'b01:   s = SIZE_H;
      default: s = SIZE_W;
    endcase
    return s;
  endfunction

  function automatic logic misaligned(input mem_access_size_t s, input logic [1:0] lo);
    logic m;
    m = 1'b0;
    if (s == SIZE_H && lo[0])       m = 1'b1;
    if (s == SIZE_W && lo != 2'b00) m = 1'b1;
    return m;
  endfunction

  // Byte lane offset after truncating to the access's natural alignment.
  function automatic logic [1:0] lane_offset(input mem_access_size_t s, input logic [1:0] lo);
    logic [1:0] o;
    case (s)
      SIZE_B:  o = lo;
      SIZE_H:  o = {lo[1], 1'b0};
      default: o = 2'b00;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane shifting, store byte-mask generation and load extension.
module lsu_align
  import lsu_pkg::*;
(
  input  mem_access_size_t size_i,
  input  logic             unsigned_i,
  input  logic [1:0]       offset_i,
  input  logic [31:0]      wdata_i,
  input  logic [31:0]      rdata_i,
  output logic [31:0]      wdata_o,
  output logic [3:0]       wmask_o,
  output logic [31:0]      rdata_o
);

  logic [31:0] shifted;
  logic [15:0] half;

  always_comb begin
    wdata_o = wdata_i;
    wmask_o = 4'b1111;
    rdata_o = rdata_i;
    shifted = rdata_i >> {offset_i, 3'b000};
    half    = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      SIZE_B: begin
        wdata_o = {4{wdata_i[7:0]}};
        wmask_o = 4'b0001 << offset_i;
        rdata_o = unsigned_i ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      SIZE_H: begin
        wdata_o = {2{wdata_i[15:0]}};
        wmask_o = 4'b0011 << offset_i;
        rdata_o = unsigned_i ? {16'd0, half} : {{16{half[15]}}, half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding request, IDLE/REQ/WAIT_RD/RESP handshake FSM.
// Define LSU_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors instead of truncating.
module lsu
  import lsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_is_store_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [4:0]  req_rd_i,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wmask_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        resp_valid_o,
  output logic        resp_we_o,
  output logic [4:0]  resp_rd_o,
  output logic [31:0] resp_data_o,
  output logic        resp_err_o
);

  lsu_state_t       state_q, state_d;
  logic             is_store_q, err_q;
  logic [2:0]       funct3_q;
  logic [31:0]      addr_q, wdata_q, data_q, data_d;
  logic [4:0]       rd_q;
  logic             accept, req_err, load_ok, in_req;
  mem_access_size_t size_q;
  logic [31:0]      al_wdata, al_rdata;
  logic [3:0]       al_wmask;

  always_comb begin
    accept = req_valid_i && (state_q == S_IDLE);
`ifdef LSU_MISALIGN_TRAP_EN
    req_err = f3_illegal(req_is_store_i, req_funct3_i) ||
              misaligned(f3_size(req_funct3_i), req_addr_i[1:0]);
`else
    req_err = f3_illegal(req_is_store_i, req_funct3_i);
`endif
    size_q = f3_size(funct3_q);
  end

  lsu_align u_align (
    .size_i     (size_q),
    .unsigned_i (funct3_q[2]),
    .offset_i   (lane_offset(size_q, addr_q[1:0])),
    .wdata_i    (wdata_q),
    .rdata_i    (mem_rdata_i),
    .wdata_o    (al_wdata),
    .wmask_o    (al_wmask),
    .rdata_o    (al_rdata)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = req_err ? S_RESP : S_REQ;
          data_d  = '0;
        end
      end
      S_REQ: begin
        if (mem_req_ready_i) state_d = is_store_q ? S_RESP : S_WAIT_RD;
      end
      S_WAIT_RD: begin
        if (mem_rvalid_i) begin
          state_d = S_RESP;
          data_d  = al_rdata;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Memory payload is gated to zero outside REQ so idle outputs read as 0.
  always_comb begin
    in_req          = (state_q == S_REQ);
    req_ready_o     = (state_q == S_IDLE);
    mem_req_valid_o = in_req;
    mem_we_o        = in_req && is_store_q;
    mem_addr_o      = in_req ? {addr_q[31:2], 2'b00} : '0;
    mem_wdata_o     = (in_req && is_store_q) ? al_wdata : '0;
    mem_wmask_o     = (in_req && is_store_q) ? al_wmask : '0;
    load_ok         = (state_q == S_RESP) && !is_store_q && !err_q;
    resp_valid_o    = (state_q == S_RESP);
    resp_err_o      = (state_q == S_RESP) && err_q;
    resp_rd_o       = (state_q == S_RESP) ? rd_q : '0;
    resp_we_o       = load_ok && (rd_q != '0);
    resp_data_o     = load_ok ? data_q : '0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      is_store_q <= 1'b0;
      err_q      <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      data_q     <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      if (accept) begin
        is_store_q <= req_is_store_i;
        err_q      <= req_err;
        funct3_q   <= req_funct3_i;
        addr_q     <= req_addr_i;
        wdata_q    <= req_wdata_i;
        rd_q       <= req_rd_i;
      end
    end
  end

endmodule
